// File: rtl/preimage_search.sv
// rtl/preimage_search.sv - exhaustive input-assignment search over an external CUT
// Optional PREIMAGE_COUNT_EN: try every assignment and count all matching ones.
module preimage_search #(
    parameter int N_IN   = 2,
    parameter int N_OUT  = 1,
    parameter int SETTLE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [N_OUT-1:0] target,
    output logic [N_IN-1:0]  cut_in,
    input  logic [N_OUT-1:0] cut_out,
    output logic             busy,
    output logic             done,
    output logic             sat,
    output logic [N_IN-1:0]  model
`ifdef PREIMAGE_COUNT_EN
    ,
    output logic [N_IN:0]    sol_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APPLY  = 2'd1,
        SAMPLE = 2'd2,
        FINISH = 2'd3
    } state_t;

    // With no settle time the CUT is sampled on every cycle and APPLY is skipped.
    localparam state_t RUN_STATE = (SETTLE == 0) ? SAMPLE : APPLY;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [N_IN:0] VEC_LAST = {1'b0, {N_IN{1'b1}}};

    state_t             state;
    logic [N_IN:0]      vec;
    logic [N_IN:0]      vec_next;
    logic [3:0]         settle_cnt;
    logic [N_OUT-1:0]   target_q;
    logic               match;
    logic               last_vec;

    assign vec_next = vec + 1'b1;
    assign match    = (cut_out == target_q);
    assign last_vec = (vec == VEC_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            target_q   <= '0;
            cut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            sat        <= 1'b0;
            model      <= '0;
`ifdef PREIMAGE_COUNT_EN
            sol_count  <= '0;
`endif
        end else begin
            case (state)
                IDLE, FINISH: begin
                    if (start) begin
                        target_q   <= target;
                        vec        <= '0;
                        cut_in     <= '0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        sat        <= 1'b0;
`ifdef PREIMAGE_COUNT_EN
                        sol_count  <= '0;
`endif
                        state      <= RUN_STATE;
                    end
                end

                APPLY: begin
                    settle_cnt <= settle_cnt + 4'd1;
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end
                end

                SAMPLE: begin
`ifdef PREIMAGE_COUNT_EN
                    if (match) begin
                        sol_count <= sol_count + 1'b1;
                        if (sol_count == '0) begin
                            model <= vec[N_IN-1:0];
                        end
                    end
                    if (last_vec) begin
                        sat   <= match || (sol_count != '0);
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FINISH;
                    end else begin
                        vec        <= vec_next;
                        cut_in     <= vec_next[N_IN-1:0];
                        settle_cnt <= '0;
                        state      <= RUN_STATE;
                    end
`else
                    if (match) begin
                        model <= vec[N_IN-1:0];
                        sat   <= 1'b1;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FINISH;
                    end else if (last_vec) begin
                        sat   <= 1'b0;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= FINISH;
                    end else begin
                        vec        <= vec_next;
                        cut_in     <= vec_next[N_IN-1:0];
                        settle_cnt <= '0;
                        state      <= RUN_STATE;
                    end
`endif
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_preimage_search.sv
// tb/tb_preimage_search.sv - directed bench for preimage_search driving a NAND CUT
// Expectations follow PREIMAGE_COUNT_EN when it is defined.
module tb_preimage_search;

    logic       clk = 1'b0;
    logic       rst;
    logic       start0, start3;
    logic [0:0] target0, target3;
    logic [1:0] cut_in0, cut_in3;
    logic [0:0] cut_out0, cut_out3;
    logic       busy0, done0, sat0, busy3, done3, sat3;
    logic [1:0] model0, model3;
    logic       const_one;
`ifdef PREIMAGE_COUNT_EN
    logic [2:0] sol_count0, sol_count3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign cut_out0 = const_one ? 1'b1 : ~(cut_in0[0] & cut_in0[1]);
    assign cut_out3 = ~(cut_in3[0] & cut_in3[1]);

    preimage_search #(.N_IN(2), .N_OUT(1), .SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start0), .target(target0),
        .cut_in(cut_in0), .cut_out(cut_out0),
        .busy(busy0), .done(done0), .sat(sat0), .model(model0)
`ifdef PREIMAGE_COUNT_EN
        , .sol_count(sol_count0)
`endif
    );

    preimage_search #(.N_IN(2), .N_OUT(1), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .target(target3),
        .cut_in(cut_in3), .cut_out(cut_out3),
        .busy(busy3), .done(done3), .sat(sat3), .model(model3)
`ifdef PREIMAGE_COUNT_EN
        , .sol_count(sol_count3)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; start0 = 1'b0; start3 = 1'b0;
        target0 = 1'b0; target3 = 1'b0; const_one = 1'b0;

        // reset state
        tick(2);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_sat", sat0, 0);
        check("rst_model", model0, 0);
        check("rst_cut_in", cut_in0, 0);
        check("rst_busy3", busy3, 0);
        rst = 1'b0;
        tick(1);

        // target=1: vector 0 already matches
        target0 = 1'b1; start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        check("t2_busy_k", busy0, 1);
        check("t2_done_k", done0, 0);
        check("t2_cut_in_k", cut_in0, 0);
`ifdef PREIMAGE_COUNT_EN
        tick(3);
        check("t2_done_k3", done0, 0);
        tick(1);
        check("t2_count", sol_count0, 3);
`else
        tick(1);
`endif
        check("t2_done", done0, 1);
        check("t2_sat", sat0, 1);
        check("t2_model", model0, 0);
        check("t2_busy", busy0, 0);
        tick(2);
        check("t2_done_hold", done0, 1);

        // target=0: only vector 3 matches
        target0 = 1'b0; start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        check("t3_done_clr", done0, 0);
        check("t3_cut_in0", cut_in0, 0);
        for (int i = 1; i < 4; i++) begin
            tick(1);
            check("t3_cut_in", cut_in0, i);
            check("t3_done_early", done0, 0);
        end
        tick(1);
        check("t3_done", done0, 1);
        check("t3_sat", sat0, 1);
        check("t3_model", model0, 3);
        check("t3_cut_hold", cut_in0, 3);
`ifdef PREIMAGE_COUNT_EN
        check("t3_count", sol_count0, 1);
`endif

        // constant-1 CUT, target=0: UNSAT; start and target changes while busy ignored
        const_one = 1'b1; target0 = 1'b0; start0 = 1'b1;
        tick(1);
        target0 = 1'b1;
        for (int i = 1; i < 4; i++) begin
            tick(1);
            check("t4_busy", busy0, 1);
            check("t4_cut_in", cut_in0, i);
        end
        start0 = 1'b0;
        tick(1);
        check("t4_done", done0, 1);
        check("t4_sat", sat0, 0);
        check("t4_busy_end", busy0, 0);
        check("t4_cut_hold", cut_in0, 3);
`ifdef PREIMAGE_COUNT_EN
        check("t4_count", sol_count0, 0);
`endif
        const_one = 1'b0;

        // SETTLE=3: each vector held four cycles, match on vector 3 at k+16
        target3 = 1'b0; start3 = 1'b1;
        tick(1);
        start3 = 1'b0;
        check("t5_busy_k", busy3, 1);
        for (int j = 1; j < 16; j++) begin
            tick(1);
            check("t5_cut_in", cut_in3, j >> 2);
            check("t5_done_early", done3, 0);
        end
        tick(1);
        check("t5_done", done3, 1);
        check("t5_sat", sat3, 1);
        check("t5_model", model3, 3);
`ifdef PREIMAGE_COUNT_EN
        check("t5_count", sol_count3, 1);
`endif

        // reset during a search aborts on that edge
        target0 = 1'b0; start0 = 1'b1;
        tick(1);
        start0 = 1'b0;
        tick(1);
        check("t6_cut_mid", cut_in0, 1);
        rst = 1'b1;
        tick(1);
        check("t6_busy", busy0, 0);
        check("t6_done", done0, 0);
        check("t6_sat", sat0, 0);
        check("t6_model", model0, 0);
        check("t6_cut_in", cut_in0, 0);

        // start coinciding with reset: reset wins
        start0 = 1'b1;
        tick(1);
        check("t7_busy", busy0, 0);
        rst = 1'b0; start0 = 1'b0;
        tick(1);
        check("t7_busy_after", busy0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
